// File: rtl/player_motion_pkg.sv
// rtl/player_motion_pkg.sv - shared types and helpers for the multi-player motion path
package player_motion_pkg;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } motion_state_t;

    localparam int SRC_NES = 0;
    localparam int SRC_IR  = 1;
    localparam int SRC_PS2 = 2;

    // Opposing presses on an axis cancel, so only a lone press on an axis counts.
    function automatic logic dir_active(input dir_t d);
        return (d.up ^ d.down) | (d.left ^ d.right);
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// rtl/player_motion_if.sv - controller-source inputs and per-player position outputs
interface player_motion_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SRC     = 3,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9
);
    localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_PLAYERS*CW-1:0]      choice;
    logic [NUM_SRC*4-1:0]           src_dir;
    logic [NUM_SRC-1:0]             src_readable;
    logic [NUM_PLAYERS*X_WIDTH-1:0] x;
    logic [NUM_PLAYERS*Y_WIDTH-1:0] y;
    logic [NUM_PLAYERS-1:0]         moved;

    modport master (
        output choice, src_dir, src_readable,
        input  x, y, moved
    );

    modport slave (
        input  choice, src_dir, src_readable,
        output x, y, moved
    );
endinterface

// File: rtl/player_motion_axis_fsm.sv
// rtl/player_motion_axis_fsm.sv - per-player press/auto-repeat FSM with saturating X/Y registers
module player_axis_fsm
    import player_motion_pkg::*;
#(
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 9,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int STEP         = 4,
    parameter int REPEAT_DELAY = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  dir_t               i_dir,
    output logic [X_WIDTH-1:0] o_x,
    output logic [Y_WIDTH-1:0] o_y,
    output logic               o_moved
);
    localparam int RCW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RCW-1:0] RC_LAST = RCW'(REPEAT_DELAY - 1);

    motion_state_t      r_state;
    motion_state_t      w_next;
    logic [RCW-1:0]     r_rcnt;
    logic               w_active;
    logic               w_delay_done;
    logic               w_step;
    logic [X_WIDTH-1:0] r_x;
    logic [X_WIDTH-1:0] w_x_next;
    logic [X_WIDTH:0]   w_x_sum;
    logic [Y_WIDTH-1:0] r_y;
    logic [Y_WIDTH-1:0] w_y_next;
    logic [Y_WIDTH:0]   w_y_sum;
    logic               r_moved;

    assign w_active     = dir_active(i_dir);
    assign w_delay_done = (r_rcnt == RC_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_active && i_tick) w_next = DELAY;
            DELAY:   if (!w_active) w_next = IDLE;
                     else if (i_tick && w_delay_done) w_next = REPEAT;
            REPEAT:  if (!w_active) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_step = 1'b0;
        case (r_state)
            IDLE:    w_step = w_active && i_tick;
            DELAY:   w_step = w_active && i_tick && w_delay_done;
            REPEAT:  w_step = w_active && i_tick;
            default: w_step = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcnt <= '0;
        end else if (r_state != DELAY || !w_active) begin
            r_rcnt <= '0;
        end else if (i_tick && !w_delay_done) begin
            r_rcnt <= r_rcnt + 1'b1;
        end
    end

    // One guard bit on the add lets an overshoot past the bound be seen before clamping.
    always_comb begin
        w_x_sum  = {1'b0, r_x} + (X_WIDTH+1)'(STEP);
        w_y_sum  = {1'b0, r_y} + (Y_WIDTH+1)'(STEP);
        w_x_next = r_x;
        w_y_next = r_y;
        if (i_dir.right && !i_dir.left) begin
            w_x_next = (w_x_sum > (X_WIDTH+1)'(X_MAX)) ? X_WIDTH'(X_MAX) : w_x_sum[X_WIDTH-1:0];
        end else if (i_dir.left && !i_dir.right) begin
            w_x_next = (r_x < X_WIDTH'(STEP)) ? '0 : r_x - X_WIDTH'(STEP);
        end
        if (i_dir.down && !i_dir.up) begin
            w_y_next = (w_y_sum > (Y_WIDTH+1)'(Y_MAX)) ? Y_WIDTH'(Y_MAX) : w_y_sum[Y_WIDTH-1:0];
        end else if (i_dir.up && !i_dir.down) begin
            w_y_next = (r_y < Y_WIDTH'(STEP)) ? '0 : r_y - Y_WIDTH'(STEP);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_moved <= 1'b0;
        end else if (w_step) begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_moved <= (w_x_next != r_x) || (w_y_next != r_y);
        end else begin
            r_moved <= 1'b0;
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_moved = r_moved;

endmodule

// File: rtl/player_motion.sv
// rtl/player_motion.sv - tick divider, per-source snapshots with stale timeout, per-player source mux
module player_motion
    import player_motion_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_SRC      = 3,
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 9,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int STEP         = 4,
    parameter int TICK_DIV     = 416666,
    parameter int REPEAT_DELAY = 8,
    parameter int STALE_TICKS  = 30
) (
    input logic            i_clk,
    input logic            i_rst_n,
    player_motion_if.slave bus
);
    localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STALE_TICKS + 1);

    logic [DW-1:0]          r_div;
    logic                   w_tick;
    dir_t                   r_snap  [NUM_SRC];
    logic [SW-1:0]          r_stale [NUM_SRC];
    dir_t                   w_eff   [NUM_SRC];
    dir_t                   w_pdir  [NUM_PLAYERS];
    logic [X_WIDTH-1:0]     w_x     [NUM_PLAYERS];
    logic [Y_WIDTH-1:0]     w_y     [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] w_moved;

    assign w_tick = (r_div == DW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                r_snap[s]  <= '0;
                r_stale[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (bus.src_readable[s]) begin
                    r_snap[s]  <= dir_t'(bus.src_dir[s*4 +: 4]);
                    r_stale[s] <= '0;
                end else if (w_tick && r_stale[s] != SW'(STALE_TICKS)) begin
                    r_stale[s] <= r_stale[s] + 1'b1;
                    if (r_stale[s] == SW'(STALE_TICKS - 1)) r_snap[s] <= '0;
                end
            end
        end
    end

    // The expiring tick already sees an empty snapshot, so it can never produce a step.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            w_eff[s] = r_snap[s];
            if (w_tick && !bus.src_readable[s] && r_stale[s] == SW'(STALE_TICKS - 1)) begin
                w_eff[s] = '0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_pdir[p] = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (bus.choice[p*CW +: CW] == CW'(s)) w_pdir[p] = w_eff[s];
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        player_axis_fsm #(
            .X_WIDTH      (X_WIDTH),
            .Y_WIDTH      (Y_WIDTH),
            .X_MAX        (X_MAX),
            .Y_MAX        (Y_MAX),
            .STEP         (STEP),
            .REPEAT_DELAY (REPEAT_DELAY)
        ) u_axis (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_tick  (w_tick),
            .i_dir   (w_pdir[p]),
            .o_x     (w_x[p]),
            .o_y     (w_y[p]),
            .o_moved (w_moved[p])
        );
    end

    always_comb begin
        bus.x = '0;
        bus.y = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            bus.x[p*X_WIDTH +: X_WIDTH] = w_x[p];
            bus.y[p*Y_WIDTH +: Y_WIDTH] = w_y[p];
        end
        bus.moved = w_moved;
    end

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - randomized and directed checks of player_motion against a tick-level model
module tb_player_motion;
    localparam int NP = 2;
    localparam int NS = 3;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int XM = 639;
    localparam int YM = 479;
    localparam int ST = 4;
    localparam int TD = 4;
    localparam int RD = 3;
    localparam int SK = 5;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    logic [3:0] m_snap [NS];
    int         m_age  [NS];
    int         m_x    [NP];
    int         m_y    [NP];
    int         m_held [NP];
    int         m_n;

    player_motion_if #(.NUM_PLAYERS(NP), .NUM_SRC(NS), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    player_motion #(
        .NUM_PLAYERS(NP), .NUM_SRC(NS), .X_WIDTH(XW), .Y_WIDTH(YW),
        .X_MAX(XM), .Y_MAX(YM), .STEP(ST), .TICK_DIV(TD),
        .REPEAT_DELAY(RD), .STALE_TICKS(SK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_snap[s] = 4'd0;
            m_age[s]  = 0;
        end
        for (int p = 0; p < NP; p++) begin
            m_x[p]    = 0;
            m_y[p]    = 0;
            m_held[p] = 0;
        end
        m_n = 0;
    endtask

    // Entered and left at a falling edge: drive, predict, let one rising edge pass, compare.
    task automatic cyc(input logic [3:0] ch, input logic [11:0] dir, input logic [2:0] rd);
        logic                tick;
        logic [3:0]          eff [NS];
        logic [3:0]          d;
        int                  sel, dx, dy, nx, ny;
        logic [NP-1:0]       e_mv;
        logic [NP*XW-1:0]    e_x;
        logic [NP*YW-1:0]    e_y;
        bus.choice       = ch;
        bus.src_dir      = dir;
        bus.src_readable = rd;
        tick = ((m_n % TD) == TD - 1);
        for (int s = 0; s < NS; s++) begin
            eff[s] = (!rd[s] && tick && (m_age[s] + 1 >= SK)) ? 4'd0 : m_snap[s];
        end
        for (int p = 0; p < NP; p++) begin
            sel = int'(ch[2*p +: 2]);
            d   = (sel < NS) ? eff[sel] : 4'd0;
            dx  = (d[0] && !d[1]) ? 1 : ((d[1] && !d[0]) ? -1 : 0);
            dy  = (d[2] && !d[3]) ? 1 : ((d[3] && !d[2]) ? -1 : 0);
            e_mv[p] = 1'b0;
            if (dx == 0 && dy == 0) begin
                m_held[p] = 0;
            end else if (tick) begin
                if (m_held[p] == 0 || m_held[p] >= RD) begin
                    nx = clampi(m_x[p] + dx * ST, XM);
                    ny = clampi(m_y[p] + dy * ST, YM);
                    e_mv[p] = (nx != m_x[p]) || (ny != m_y[p]);
                    m_x[p] = nx;
                    m_y[p] = ny;
                end
                if (m_held[p] < RD) m_held[p]++;
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (rd[s]) begin
                m_snap[s] = dir[4*s +: 4];
                m_age[s]  = 0;
            end else if (tick && m_age[s] < SK) begin
                m_age[s]++;
                if (m_age[s] >= SK) m_snap[s] = 4'd0;
            end
        end
        m_n++;
        for (int p = 0; p < NP; p++) begin
            e_x[XW*p +: XW] = XW'(m_x[p]);
            e_y[YW*p +: YW] = YW'(m_y[p]);
        end
        @(posedge clk);
        #1;
        chk("x", 32'(bus.x), 32'(e_x));
        chk("y", 32'(bus.y), 32'(e_y));
        chk("moved", 32'(bus.moved), 32'(e_mv));
        @(negedge clk);
    endtask

    // Holds one direction on one source, refreshing well inside the stale window.
    task automatic hold(input logic [3:0] ch, input int src, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(ch, {3{d}}, (i % 8 == 0) ? 3'(1 << src) : 3'b000);
        end
    endtask

    initial begin
        logic [3:0]  ch;
        logic [2:0]  rd;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.choice       = '0;
        bus.src_dir      = '0;
        bus.src_readable = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_x", 32'(bus.x), 32'd0);
        chk("reset_y", 32'(bus.y), 32'd0);
        chk("reset_moved", 32'(bus.moved), 32'd0);
        rst_n = 1'b1;

        // press then auto-repeat on NES, player 1 on an out-of-range select
        hold(4'b1100, 0, 4'b0001, 120);
        // right and down into the upper bounds
        hold(4'b1100, 0, 4'b0001, 700);
        hold(4'b0000, 0, 4'b0100, 560);
        // up+down cancel while moving left; then up+left diagonal to the origin
        hold(4'b0000, 0, 4'b1110, 200);
        hold(4'b0000, 0, 4'b1010, 700);

        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) ch = 4'($urandom);
            rd = 3'b000;
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 7) == 0) rd[s] = 1'b1;
            end
            cyc(ch, 12'($urandom), rd);
        end

        // single Down strobe on IR, then let it go stale
        cyc(4'b0101, {3{4'b0100}}, 3'b010);
        for (int i = 0; i < 40; i++) cyc(4'b0101, 12'd0, 3'b000);

        // both players share PS2; refresh lands exactly on the expiring tick
        for (int i = 0; i < 120; i++) begin
            rd = (i == 0 || ((m_n % TD) == TD - 1 && m_age[2] == SK - 1)) ? 3'b100 : 3'b000;
            cyc(4'b1010, {3{4'b0001}}, rd);
        end
        // player 1 moves to the empty IR source mid-hold
        for (int i = 0; i < 60; i++) begin
            rd = ((m_n % TD) == TD - 1 && m_age[2] == SK - 1) ? 3'b100 : 3'b000;
            cyc(4'b0110, {3{4'b0001}}, rd);
        end
        hold(4'b1111, 2, 4'b0001, 30);

        // asynchronous reset between edges while player 0 is moving
        hold(4'b1100, 0, 4'b0001, 40);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", 32'(bus.x), 32'd0);
        chk("async_rst_y", 32'(bus.y), 32'd0);
        chk("async_rst_moved", 32'(bus.moved), 32'd0);
        bus.src_readable = '0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        hold(4'b1100, 0, 4'b0001, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Multi-player successor to the single-player input/position path.
- Takes decoded direction snapshots from NUM_SRC controller sources (NES/SNES, IR, PS2 by default), routes one source to each of NUM_PLAYERS players via per-player selects, and maintains clamped X/Y position registers for the renderer.
- Adds press/auto-repeat timing, stale-controller timeout and configurable step size and bounds.

Parameters:
- NUM_PLAYERS, 2, number of independent player position channels
- NUM_SRC, 3, number of controller sources (index 0 NES, 1 IR, 2 PS2)
- X_WIDTH, 10, X position width in bits
- Y_WIDTH, 9, Y position width in bits
- X_MAX, 639, largest legal X (≤ 2**X_WIDTH-1)
- Y_MAX, 479, largest legal Y (≤ 2**Y_WIDTH-1)
- STEP, 4, pixels moved per step
- TICK_DIV, 416666, Clock cycles per motion tick (≥2)
- REPEAT_DELAY, 8, ticks a direction is held before auto-repeat starts
- STALE_TICKS, 30, ticks with no Readable before a source's snapshot is cleared

Ports:
- Clock  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Choice  in  NUM_PLAYERS*$clog2(NUM_SRC)  per-player source select; out-of-range index = no input
- SrcDir  in  NUM_SRC*4  per source {Up,Down,Left,Right}, valid only with SrcReadable
- SrcReadable  in  1*NUM_SRC  per-source single-cycle valid strobe
- X  out  NUM_PLAYERS*X_WIDTH  player X positions, player 0 in LSBs
- Y  out  NUM_PLAYERS*Y_WIDTH  player Y positions
- Moved  out  NUM_PLAYERS  one-cycle pulse when that player's position changed

Behaviour:
- Reset (async, Reset_n=0): X=0, Y=0, Moved=0, snapshots=0, all counters=0, every player FSM in IDLE. Release takes effect on the next Clock edge.
- Source capture: on SrcReadable[s]=1, snap[s] is loaded with SrcDir[s] on that edge and stale[s] is cleared.
  - stale[s] increments on each tick without Readable. When it reaches STALE_TICKS, snap[s] is cleared to 0 and stale[s] saturates there.
  - If Readable and a tick coincide, Readable wins (stale[s]=0).
- Tick: one shared divider counting 0..TICK_DIV-1. tick=1 for exactly one cycle at wrap.
- Direction resolve (combinational, per player): dir = snap[Choice[p]].
  - Up&Down together cancel to no vertical motion; Left&Right together cancel to no horizontal motion.
  - active = any non-cancelled axis.
  - Diagonals are allowed; both axes move.
- Per-player FSM (states IDLE, DELAY, REPEAT):
  - IDLE: when active rises, step once on the next tick (not immediately) and go to DELAY with rcnt=0.
  - DELAY: each tick with active set, rcnt++. When rcnt reaches REPEAT_DELAY-1, step on that tick and go to REPEAT.
  - REPEAT: step on every tick while active.
  - Any state: when active=0, go to IDLE on the next edge with no step.
  - A direction change while active stays in the current state; the new direction is used.
  - A Choice change mid-hold follows the same rule, evaluated against the new source.
- Step arithmetic, per axis, saturating:
  - New value is clamped to [0, X_MAX] or [0, Y_MAX]; no wrap-around.
  - Use unsigned compare before subtract (if X < STEP then X := 0). Use X_WIDTH+1-bit add, then clamp.
- Moved[p]=1 for the single cycle after X or Y of player p actually changes. A step blocked by a bound gives Moved=0.
- Latency: step-tick edge → X/Y updated on that same edge (registered outputs). Moved is asserted in the same cycle X/Y show the new value.
- Players are independent. Two players may occupy the same position and may share a source.

Decomposition:
- Package player_motion_pkg:
  - typedef dir_t (struct packed Up, Down, Left, Right)
  - enum motion_state_t {IDLE, DELAY, REPEAT}
  - source index localparams SRC_NES=0, SRC_IR=1, SRC_PS2=2
- Sub-module player_axis_fsm: one instance per player via generate. It contains the FSM, rcnt and the two saturating position registers.
- Top level holds the tick divider, the per-source snapshot/stale logic and the Choice mux.

Test Plan:
- Reset mid-operation: hold Right on player 0 (X=100), assert Reset_n=0 asynchronously between edges → X=0, Y=0 and Moved=0 immediately; FSM in IDLE after release.
- Press/repeat (TICK_DIV=4, REPEAT_DELAY=3, STEP=4): player 0 Choice=0, one Readable with Right held → X=4 at first tick; no further step until the 3rd tick of DELAY (X=8); then +4 every tick.
- Clamp (X_MAX=639, X=637): Right step → X=639 and Moved=1; next step → X=639 and Moved=0. X=2 with Left step → X=0.
- Cancel/diagonal: Up+Down+Right → only X changes. Up+Left from (8,8) → (4,4) on one step.
- Stale (STALE_TICKS=5): single Readable with Down, no further strobes → Y advances for 4 ticks, snap cleared at the 5th tick with no step, FSM returns to IDLE. A Readable coinciding with the 5th tick keeps the snapshot.
- Multi-player/select: players 0 and 1 both Choice=2 with Left → both move identically. Switch player 1 to Choice=1 (IR snap=0) mid-hold → player 1 returns to IDLE, player 0 keeps repeating. Choice=3 → no motion.
